// File: rtl/res_pack_buffer.sv
// Result-packing buffer: gathers DEPTH words into one vector held in a registered output slot.
// Define RES_BUF_FLUSH_EN to add the flush input and out_cnt output for partial vectors.
module res_pack_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [CNT_W-1:0]        fill_cnt,
    output logic                    full,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEPTH*DATA_W-1:0] out_data
`ifdef RES_BUF_FLUSH_EN
    ,
    input  logic                    flush,
    output logic [CNT_W-1:0]        out_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    // The final word goes straight to the output slot, so only DEPTH-1 lanes are stored.
    logic [DATA_W-1:0]       bank [DEPTH-1];
    logic [DEPTH*DATA_W-1:0] full_vec;
    logic                    last;
    logic                    accept;

    assign last     = (fill_cnt == LAST_CNT);
    assign full     = last;
    assign in_ready = !clear && !(last && out_valid);
    assign accept   = in_valid && in_ready;

    always_comb begin
        full_vec = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            full_vec[i*DATA_W +: DATA_W] = bank[i];
        end
        full_vec[(DEPTH-1)*DATA_W +: DATA_W] = in_data;
    end

`ifdef RES_BUF_FLUSH_EN
    logic [DEPTH*DATA_W-1:0] part_vec;

    // Lanes at or above fill_cnt hold stale data from earlier vectors and must read as zero.
    always_comb begin
        part_vec = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (CNT_W'(i) < fill_cnt) begin
                part_vec[i*DATA_W +: DATA_W] = bank[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < DEPTH - 1; i++) begin
                bank[i] <= '0;
            end
`ifdef RES_BUF_FLUSH_EN
            out_cnt   <= '0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Completion needs out_valid low (see in_ready), so it never collides with a pop.
            if (accept) begin
                if (last) begin
                    out_data  <= full_vec;
                    out_valid <= 1'b1;
                    fill_cnt  <= '0;
`ifdef RES_BUF_FLUSH_EN
                    out_cnt   <= CNT_W'(DEPTH);
`endif
                end else begin
                    bank[fill_cnt[IDX_W-1:0]] <= in_data;
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end
            end
`ifdef RES_BUF_FLUSH_EN
            else if (flush && (fill_cnt != '0) && !out_valid) begin
                out_data  <= part_vec;
                out_cnt   <= fill_cnt;
                out_valid <= 1'b1;
                fill_cnt  <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_res_pack_buffer.sv
// Scoreboard bench for res_pack_buffer: a DEPTH=4 instance for directed vectors and a
// DEPTH=8/16-bit instance for a randomized stream; reference models run on the falling edge.
module tb_res_pack_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic [2:0]   fill_cnt;
    logic         full;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
`ifdef RES_BUF_FLUSH_EN
    logic         flush = 1'b0;
    logic [2:0]   out_cnt;
    logic         b_flush = 1'b0;
    logic [3:0]   b_out_cnt;
`endif

    logic         b_clear = 1'b0;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [15:0]  b_in_data = '0;
    logic [3:0]   b_fill_cnt;
    logic         b_full;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [127:0] b_out_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    res_pack_buffer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fill_cnt(fill_cnt), .full(full),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef RES_BUF_FLUSH_EN
        , .flush(flush), .out_cnt(out_cnt)
`endif
    );

    res_pack_buffer #(.DATA_W(16), .DEPTH(8)) dut_wide (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .fill_cnt(b_fill_cnt), .full(b_full),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef RES_BUF_FLUSH_EN
        , .flush(b_flush), .out_cnt(b_out_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Model of the DEPTH=4 instance: expected vectors queue up as words are accepted and
    // are popped and compared when the consumer takes them.
    logic [31:0] a_q[$];
    logic [31:0] a_part = '0;
    int          a_n = 0;
    logic        a_ready;
    logic        a_had;

    always @(negedge clk) begin
        a_ready = !clear && !(a_n == 3 && a_q.size() != 0);
        checkOutput("a_fill_cnt", 128'(fill_cnt), 128'(a_n));
        checkOutput("a_out_valid", 128'(out_valid), 128'(a_q.size() != 0));
        checkOutput("a_in_ready", 128'(in_ready), 128'(a_ready));
        checkOutput("a_full", 128'(full), 128'(a_n == 3));
        if (a_q.size() != 0) checkOutput("a_out_data", 128'(out_data), 128'(a_q[0]));
        if (rst || clear) begin
            a_n = 0;
            a_part = '0;
            a_q.delete();
        end else begin
            a_had = (a_q.size() != 0);
            if (a_had && out_ready) void'(a_q.pop_front());
            if (in_valid && a_ready) begin
                a_part[a_n*8 +: 8] = in_data;
                a_n++;
                if (a_n == 4) begin
                    a_q.push_back(a_part);
                    a_part = '0;
                    a_n = 0;
                end
            end
`ifdef RES_BUF_FLUSH_EN
            else if (flush && a_n != 0 && !a_had) begin
                a_q.push_back(a_part);
                a_part = '0;
                a_n = 0;
            end
`endif
        end
    end

    // Same model for the wide instance, which only sees random traffic and reset.
    logic [127:0] b_q[$];
    logic [127:0] b_part = '0;
    int           b_n = 0;
    int           b_acc = 0;
    int           b_pops = 0;
    logic         b_ready;

    always @(negedge clk) begin
        b_ready = !b_clear && !(b_n == 7 && b_q.size() != 0);
        checkOutput("b_fill_cnt", 128'(b_fill_cnt), 128'(b_n));
        checkOutput("b_out_valid", 128'(b_out_valid), 128'(b_q.size() != 0));
        checkOutput("b_in_ready", 128'(b_in_ready), 128'(b_ready));
        checkOutput("b_full", 128'(b_full), 128'(b_n == 7));
        if (b_q.size() != 0) checkOutput("b_out_data", b_out_data, b_q[0]);
        if (rst || b_clear) begin
            b_n = 0;
            b_part = '0;
            b_q.delete();
        end else begin
            if (b_q.size() != 0 && b_out_ready) begin
                void'(b_q.pop_front());
                b_pops++;
            end
            if (b_in_valid && b_ready) begin
                b_part[b_n*16 +: 16] = b_in_data;
                b_n++;
                b_acc++;
                if (b_n == 8) begin
                    b_q.push_back(b_part);
                    b_part = '0;
                    b_n = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        #1;
        applyStimulus(0, 8'h00, 0);
        applyStimulus(0, 8'h00, 0);
        rst = 1'b0;
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_out_data", 128'(out_data), 128'(0));
        checkOutput("reset_fill_cnt", 128'(fill_cnt), 128'(0));

        // Streaming with a consumer that is always ready.
        applyStimulus(1, 8'h11, 1);
        applyStimulus(1, 8'h22, 1);
        applyStimulus(1, 8'h33, 1);
        applyStimulus(1, 8'h44, 1);
        checkOutput("t1_valid", 128'(out_valid), 128'(1));
        checkOutput("t1_data", 128'(out_data), 128'(32'h44332211));
        checkOutput("t1_fill", 128'(fill_cnt), 128'(0));
        applyStimulus(0, 8'h00, 1);
        checkOutput("t1_pop_valid", 128'(out_valid), 128'(0));
        checkOutput("t1_hold_data", 128'(out_data), 128'(32'h44332211));

        // Consumer stalled: the second vector backs up until the slot drains.
        applyStimulus(1, 8'h01, 0);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(1, 8'h03, 0);
        applyStimulus(1, 8'h04, 0);
        checkOutput("t2_first", 128'(out_data), 128'(32'h04030201));
        applyStimulus(1, 8'h05, 0);
        applyStimulus(1, 8'h06, 0);
        applyStimulus(1, 8'h07, 0);
        checkOutput("t2_fill3", 128'(fill_cnt), 128'(3));
        checkOutput("t2_full", 128'(full), 128'(1));
        checkOutput("t2_stall_ready", 128'(in_ready), 128'(0));
        applyStimulus(1, 8'h08, 0);
        checkOutput("t2_held_fill", 128'(fill_cnt), 128'(3));
        applyStimulus(1, 8'h08, 1);
        checkOutput("t2_bubble_valid", 128'(out_valid), 128'(0));
        checkOutput("t2_bubble_ready", 128'(in_ready), 128'(1));
        applyStimulus(1, 8'h08, 0);
        checkOutput("t2_second", 128'(out_data), 128'(32'h08070605));
        checkOutput("t2_second_valid", 128'(out_valid), 128'(1));
        applyStimulus(0, 8'h00, 1);

        // Clear discards a partial vector and blocks the word offered alongside it.
        applyStimulus(1, 8'hA1, 0);
        applyStimulus(1, 8'hA2, 0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA3;
        #1;
        checkOutput("t3_clear_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("t3_clear_fill", 128'(fill_cnt), 128'(0));
        applyStimulus(1, 8'hB1, 0);
        applyStimulus(1, 8'hB2, 0);
        applyStimulus(1, 8'hB3, 0);
        applyStimulus(1, 8'hB4, 0);
        checkOutput("t3_clean_vec", 128'(out_data), 128'(32'hB4B3B2B1));
        applyStimulus(0, 8'h00, 1);

        // Reset while a vector is pending and the fill bank is half full.
        applyStimulus(1, 8'hC1, 0);
        applyStimulus(1, 8'hC2, 0);
        applyStimulus(1, 8'hC3, 0);
        applyStimulus(1, 8'hC4, 0);
        applyStimulus(1, 8'hC5, 0);
        applyStimulus(1, 8'hC6, 0);
        checkOutput("t4_pre_fill", 128'(fill_cnt), 128'(2));
        rst = 1'b1;
        applyStimulus(0, 8'h00, 0);
        rst = 1'b0;
        checkOutput("t4_rst_valid", 128'(out_valid), 128'(0));
        checkOutput("t4_rst_data", 128'(out_data), 128'(0));
        checkOutput("t4_rst_fill", 128'(fill_cnt), 128'(0));

`ifdef RES_BUF_FLUSH_EN
        applyStimulus(1, 8'hAA, 0);
        applyStimulus(1, 8'hBB, 0);
        flush = 1'b1;
        applyStimulus(0, 8'h00, 0);
        flush = 1'b0;
        checkOutput("t6_flush_valid", 128'(out_valid), 128'(1));
        checkOutput("t6_flush_data", 128'(out_data), 128'(32'h0000BBAA));
        checkOutput("t6_flush_cnt", 128'(out_cnt), 128'(2));
        applyStimulus(0, 8'h00, 1);
`endif

        // Random handshake traffic on the wide instance.
        cyc = 0;
        while (b_acc < 1000 && cyc < 20000) begin
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_in_data   = 16'($urandom);
            b_out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
            cyc++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5_words", 128'(b_acc), 128'(1000));
        checkOutput("t5_vectors", 128'(b_pops), 128'(125));
        checkOutput("t5_drained", 128'(b_q.size()), 128'(0));
        checkOutput("a_drained", 128'(a_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
